// File: rtl/score_keeper_if.sv
// Game-event inputs and score/timer/ammo display values shared between the
// score keeper and whatever drives and consumes it.
interface score_keeper_if;
  logic       vsync;
  logic       game_start;
  logic       shot_fired;
  logic       duck_hit;
  logic [6:0] score;
  logic [6:0] high_score;
  logic [6:0] time_left;
  logic [6:0] shots_left;
  logic       game_enable;
  logic       game_over;

  modport master (
    output vsync, game_start, shot_fired, duck_hit,
    input  score, high_score, time_left, shots_left, game_enable, game_over
  );

  modport slave (
    input  vsync, game_start, shot_fired, duck_hit,
    output score, high_score, time_left, shots_left, game_enable, game_over
  );
endinterface

// File: rtl/score_keeper.sv
// Game FSM plus score, ammo, frame-based timer and session high score.
// Every output is a flop; events show up one clk after they are sampled.
module score_keeper #(
  parameter int MAX_SCORE      = 99,
  parameter int GAME_TIME_S    = 60,
  parameter int FRAMES_PER_S   = 60,
  parameter int SHOTS_PER_GAME = 30
) (
  input logic           clk,
  input logic           rst,
  score_keeper_if.slave sk
);
  localparam logic [6:0] MAX_S    = 7'(MAX_SCORE);
  localparam logic [6:0] GAME_T   = 7'(GAME_TIME_S);
  localparam logic [6:0] FRAME_LS = 7'(FRAMES_PER_S - 1);
  localparam logic [6:0] SHOTS    = 7'(SHOTS_PER_GAME);

  typedef enum logic [1:0] {IDLE, PLAYING, OVER} state_t;

  state_t     state, state_nxt;
  logic       vsync_d;
  logic       frame_tick;
  logic       end_cond;
  logic [6:0] frame_cnt, frame_cnt_nxt;
  logic [6:0] score_nxt, high_nxt, time_nxt, shots_nxt;

  assign frame_tick = sk.vsync & ~vsync_d;
  // End condition looks at the registered counters, so OVER lands one cycle
  // after the last counter reaches zero.
  assign end_cond   = (sk.time_left == 7'd0) || (sk.shots_left == 7'd0);

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    score_nxt     = sk.score;
    high_nxt      = sk.high_score;
    time_nxt      = sk.time_left;
    shots_nxt     = sk.shots_left;
    if (sk.game_start) begin
      state_nxt     = PLAYING;
      frame_cnt_nxt = 7'd0;
      score_nxt     = 7'd0;
      time_nxt      = GAME_T;
      shots_nxt     = SHOTS;
    end else if (state == PLAYING) begin
      if (sk.duck_hit && (sk.score < MAX_S))
        score_nxt = sk.score + 7'd1;
      if (sk.shot_fired && (sk.shots_left != 7'd0))
        shots_nxt = sk.shots_left - 7'd1;
      if (frame_tick) begin
        if (frame_cnt >= FRAME_LS) begin
          frame_cnt_nxt = 7'd0;
          if (sk.time_left != 7'd0)
            time_nxt = sk.time_left - 7'd1;
        end else begin
          frame_cnt_nxt = frame_cnt + 7'd1;
        end
      end
      // A hit in the ending cycle still counts toward the high score.
      if (end_cond) begin
        state_nxt = OVER;
        if (score_nxt > sk.high_score)
          high_nxt = score_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      vsync_d        <= 1'b0;
      frame_cnt      <= 7'd0;
      sk.score       <= 7'd0;
      sk.high_score  <= 7'd0;
      sk.time_left   <= GAME_T;
      sk.shots_left  <= SHOTS;
      sk.game_enable <= 1'b0;
      sk.game_over   <= 1'b0;
    end else begin
      state          <= state_nxt;
      vsync_d        <= sk.vsync;
      frame_cnt      <= frame_cnt_nxt;
      sk.score       <= score_nxt;
      sk.high_score  <= high_nxt;
      sk.time_left   <= time_nxt;
      sk.shots_left  <= shots_nxt;
      sk.game_enable <= (state_nxt == PLAYING);
      sk.game_over   <= (state == PLAYING) && (state_nxt == OVER);
    end
  end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-state and score bookkeeping stage that sits directly upstream of the two-digit number drawers.
- Counts duck hits, remaining shots and remaining game time, and keeps a session high score.
- Drives registered 7-bit binary values (0..99) and the game_enable flag that the on-screen two-digit score, timer and ammo displays consume.
- Game time is counted in frames, derived from the VGA vsync input.

Parameters:
- MAX_SCORE, 99: saturation value for score and high_score; must be ≤ 99 so two decimal digits suffice.
- GAME_TIME_S, 60: game length in seconds; must be ≤ 99.
- FRAMES_PER_S, 60: vsync frames per second of game time.
- SHOTS_PER_GAME, 30: ammunition loaded at game start; must be ≤ 99.

Ports:
- clk  input  1  pixel clock (the same domain as the vga_if chain).
- rst  input  1  reset; asynchronous, active-high.
- vsync  input  1  VGA vertical sync from the timing stage, synchronous to clk; its rising edge marks one frame.
- game_start  input  1  one-cycle pulse that starts or restarts a game.
- shot_fired  input  1  one-cycle pulse per trigger pull.
- duck_hit  input  1  one-cycle pulse per confirmed hit.
- score  output  7  current score, 0..MAX_SCORE.
- high_score  output  7  best score since reset.
- time_left  output  7  seconds remaining.
- shots_left  output  7  remaining ammunition.
- game_enable  output  1  high while the FSM is in PLAYING.
- game_over  output  1  one-cycle pulse on entry to OVER.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous and active-high.
  - All outputs are registered.
- Reset values:
  - score = 0, high_score = 0, time_left = GAME_TIME_S, shots_left = SHOTS_PER_GAME.
  - game_enable = 0, game_over = 0.
  - FSM = IDLE; frame counter = 0; vsync edge register = 0.
- Frame tick:
  - frame_tick = vsync & ~vsync_d, where vsync_d is vsync delayed by one register.
  - frame_tick is one cycle wide.
- FSM states: IDLE, PLAYING, OVER.
  - IDLE --game_start--> PLAYING.
  - PLAYING --(time_left reaches 0 or shots_left reaches 0)--> OVER.
  - OVER --game_start--> PLAYING.
  - game_start while in PLAYING restarts the game: counters reload and the state stays PLAYING.
- Entry to PLAYING (the cycle after game_start is sampled):
  - score = 0, time_left = GAME_TIME_S, shots_left = SHOTS_PER_GAME, frame counter = 0.
  - game_enable = 1.
  - high_score is not changed.
- In PLAYING, per frame_tick:
  - frame counter increments.
  - When it would reach FRAMES_PER_S, it wraps to 0 and time_left decrements.
  - time_left never goes below 0.
- In PLAYING, shot_fired: shots_left decrements, saturating at 0.
- In PLAYING, duck_hit: score increments, saturating at MAX_SCORE.
- shot_fired and duck_hit in the same cycle: both take effect in that cycle.
- Transition to OVER:
  - Taken in the cycle after the registered time_left or shots_left becomes 0.
  - A duck_hit arriving in that same cycle is still counted.
  - On entry to OVER:
    - game_enable = 0.
    - game_over pulses for exactly one cycle.
    - If score > high_score, then high_score = score (takes effect in the same cycle game_over pulses).
- In IDLE and OVER:
  - shot_fired, duck_hit and frame_tick are ignored.
  - All values are held, so the final score stays displayed.
- game_start has priority over every other input in the same cycle, including a simultaneous end condition.
- Latency: each event appears on the outputs one clk after it is sampled.
- Reset mid-game: everything returns to the reset values immediately (asynchronously), and high_score is lost.
- Width rule: all counters are 7 bits wide. No arithmetic may wrap; every increment and decrement saturates.

Test Plan:
- Reset, then game_start -> next cycle: game_enable = 1, score = 0, time_left = 60, shots_left = 30, game_over = 0.
- 5 duck_hit pulses with 5 coincident shot_fired pulses -> score = 5, shots_left = 25. Then 25 further shot_fired -> shots_left = 0, one game_over pulse, game_enable = 0, high_score = 5.
- 120 vsync rising edges during PLAYING -> time_left = 58. A held-high vsync produces only one decrement per rising edge. Continuing to 3600 edges -> time_left = 0, then game_over.
- With MAX_SCORE = 99, send 105 hits (SHOTS_PER_GAME raised so the game does not end) -> score stays at 99 and never wraps to 0.
- After a game with score 5, play a game scoring 3 -> high_score remains 5. Pulse duck_hit in OVER -> score unchanged.
- Assert rst mid-game with score 12 -> all outputs take reset values with no clock edge. game_start in the same cycle as the final shot -> the game restarts with no game_over pulse.
